adc_seq_apb: RTL and testbench

APB peripheral that sequences a multi-channel ADC: scans a programmable channel mask once or continuously, stores tagged samples in a result FIFO and raises an interrupt. It sits on the APB bus under the `cmsdk_apb_slave_mux` and drives the ADC conversion handshake directly. It replaces single-channel write-only register wrappers and adds read-back, error responses and buffering.

---
 rtl/adc_seq_apb.sv | 198 +++++++++++++++++++
 tb/tb_adc_seq_apb.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_seq_apb.sv
`timescale 1ns/1ps
// adc_seq_apb: APB peripheral that scans a channel mask on an ADC and buffers tagged samples in a FIFO.
// Define ADC_SEQ_TIMEOUT_EN to enable the conversion watchdog (TMO status bit).
module adc_seq_apb #(
   parameter int ADDR_WIDTH     = 12,
   parameter int DATA_WIDTH     = 32,
   parameter int NUM_CH         = 8,
   parameter int SAMPLE_W       = 12,
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic                  PSEL,
   input  logic                  PENABLE,
   input  logic                  PWRITE,
   input  logic [ADDR_WIDTH-1:0] PADDR,
   input  logic [DATA_WIDTH-1:0] PWDATA,
   output logic [DATA_WIDTH-1:0] PRDATA,
   output logic                  PREADY,
   output logic                  PSLVERR,
   output logic                  adc_start,
   output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] adc_chsel,
   input  logic                  adc_done,
   input  logic [SAMPLE_W-1:0]   adc_data,
   output logic                  irq
);
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int ENT_W = CH_W + SAMPLE_W;
   localparam int AW    = ADDR_WIDTH - 2;
   localparam logic [AW-1:0] A_CTRL   = AW'(0);
   localparam logic [AW-1:0] A_CHMASK = AW'(1);
   localparam logic [AW-1:0] A_TRIG   = AW'(2);
   localparam logic [AW-1:0] A_STATUS = AW'(3);
   localparam logic [AW-1:0] A_DATA   = AW'(4);

   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_NEXT} state_t;

   function automatic logic [CH_W-1:0] lowest_ch(input logic [NUM_CH-1:0] m);
      lowest_ch = '0;
      for (int i = NUM_CH - 1; i >= 0; i--)
         if (m[i]) lowest_ch = CH_W'(i);
   endfunction

   // Returns {found, channel} for the nearest set mask bit strictly above cur.
   function automatic logic [CH_W:0] higher_ch(input logic [NUM_CH-1:0] m, input logic [CH_W-1:0] cur);
      higher_ch = '0;
      for (int i = NUM_CH - 1; i >= 0; i--)
         if (m[i] && (i > int'(cur))) higher_ch = {1'b1, CH_W'(i)};
   endfunction

   state_t              state_q, state_d;
   logic [CH_W-1:0]     ch_q, ch_d;
   logic                en, cont, irq_en, ovf, tmo;
   logic [NUM_CH-1:0]   chmask;
   logic [ENT_W-1:0]    mem [FIFO_DEPTH];
   logic [ENT_W-1:0]    rd_ent;
   logic [PTR_W-1:0]    wr_ptr, rd_ptr;
   logic [LVL_W-1:0]    level;
   logic [AW-1:0]       word;
   logic                access, addr_ok, wr_acc, rd_acc, trig, w1c;
   logic                busy, empty, full, pop, push, push_req, ovf_set, tmo_set;
   logic [CH_W:0]       nxt;
   logic [DATA_WIDTH-1:0] rdata;
   logic                unused_ok;

   assign word    = PADDR[ADDR_WIDTH-1:2];
   assign access  = PSEL & PENABLE;
   assign addr_ok = (word <= A_DATA);
   assign wr_acc  = access & PWRITE & addr_ok;
   assign rd_acc  = access & ~PWRITE & addr_ok;
   assign trig    = wr_acc & (word == A_TRIG) & PWDATA[0];
   assign w1c     = wr_acc & (word == A_STATUS);

   assign busy    = (state_q != S_IDLE);
   assign empty   = (level == '0);
   assign full    = (level == LVL_W'(FIFO_DEPTH));
   assign pop     = rd_acc & (word == A_DATA) & ~empty;
   assign push    = push_req & (~full | pop);
   assign ovf_set = push_req & full & ~pop;
   assign rd_ent  = mem[rd_ptr];

   assign PREADY    = 1'b1;
   assign PSLVERR   = access & ~addr_ok;
   assign PRDATA    = rd_acc ? rdata : '0;
   assign adc_start = (state_q == S_START);
   assign adc_chsel = ch_q;
   assign irq       = irq_en & (~empty | ovf | tmo);
   assign unused_ok = &{1'b0, PADDR[1:0], PWDATA, (TIMEOUT_CYCLES > 0)};

`ifdef ADC_SEQ_TIMEOUT_EN
   localparam int TC_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TC_W-1:0] TMO_LAST = TC_W'(TIMEOUT_CYCLES - 1);
   logic [TC_W-1:0] tmo_cnt;

   // Held at zero outside WAIT, so every conversion starts a fresh count.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn)                 tmo_cnt <= '0;
      else if (state_q != S_WAIT)   tmo_cnt <= '0;
      else if (tmo_cnt != TMO_LAST) tmo_cnt <= tmo_cnt + TC_W'(1);
   end
`endif

   always_comb begin
      state_d  = state_q;
      ch_d     = ch_q;
      push_req = 1'b0;
      tmo_set  = 1'b0;
      nxt      = '0;
      if (busy && !en) begin
         // Clearing EN aborts the scan; a result arriving now is discarded.
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: if (trig && en && (chmask != '0)) begin
               state_d = S_START;
               ch_d    = lowest_ch(chmask);
            end
            S_START: state_d = S_WAIT;
            S_WAIT: if (adc_done) begin
               push_req = 1'b1;
               state_d  = S_NEXT;
            end
`ifdef ADC_SEQ_TIMEOUT_EN
            else if (tmo_cnt == TMO_LAST) begin
               tmo_set = 1'b1;
               state_d = S_IDLE;
            end
`endif
            S_NEXT: begin
               nxt = higher_ch(chmask, ch_q);
               if (nxt[CH_W]) begin
                  ch_d    = nxt[CH_W-1:0];
                  state_d = S_START;
               end else if (cont && (chmask != '0)) begin
                  ch_d    = lowest_ch(chmask);
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q <= S_IDLE;
         ch_q    <= '0;
         en      <= 1'b0;
         cont    <= 1'b0;
         irq_en  <= 1'b0;
         chmask  <= '0;
         ovf     <= 1'b0;
         tmo     <= 1'b0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level   <= '0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         if (wr_acc && (word == A_CTRL))   {irq_en, cont, en} <= PWDATA[2:0];
         if (wr_acc && (word == A_CHMASK)) chmask <= PWDATA[NUM_CH-1:0];
         // A set event in the same cycle as the W1C write wins.
         ovf <= ovf_set | (ovf & ~(w1c & PWDATA[3]));
         tmo <= tmo_set | (tmo & ~(w1c & PWDATA[4]));
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      level <= level + LVL_W'(1);
         else if (pop && !push) level <= level - LVL_W'(1);
      end
   end

   always_ff @(posedge PCLK) begin
      if (push) mem[wr_ptr] <= {ch_q, adc_data};
   end

   always_comb begin
      rdata = '0;
      case (word)
         A_CTRL:   rdata[2:0] = {irq_en, cont, en};
         A_CHMASK: rdata[NUM_CH-1:0] = chmask;
         A_STATUS: begin
            rdata[4:0]  = {tmo, ovf, full, empty, busy};
            rdata[15:8] = 8'(level);
         end
         A_DATA: if (!empty) begin
            rdata[31]            = 1'b1;
            rdata[16 +: CH_W]    = rd_ent[ENT_W-1 -: CH_W];
            rdata[SAMPLE_W-1:0]  = rd_ent[SAMPLE_W-1:0];
         end
         default: rdata = '0;
      endcase
   end
endmodule

// File: tb/tb_adc_seq_apb.sv
`timescale 1ns/1ps
// tb_adc_seq_apb: directed scoreboard bench for the APB ADC scan sequencer.
module tb_adc_seq_apb;
   localparam logic [11:0] A_CTRL = 12'h000, A_CHMASK = 12'h004, A_TRIG = 12'h008,
                           A_STATUS = 12'h00C, A_DATA = 12'h010;

   logic        PCLK = 1'b0, PRESETn = 1'b0;
   logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
   logic [11:0] PADDR = '0;
   logic [31:0] PWDATA = '0;
   logic [31:0] PRDATA;
   logic        PREADY, PSLVERR, adc_start, irq;
   logic [2:0]  adc_chsel;
   logic        adc_done = 1'b0;
   logic [11:0] adc_data = '0;

   int total = 0;
   int bad = 0;

   string       nm_q[$];
   logic [31:0] d_q[$];
   logic        e_q[$];
   logic [2:0]  start_q[$];
   string       m_nm;
   logic [31:0] m_d;
   logic        m_e;
   logic [2:0]  m_ch;

   adc_seq_apb #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .NUM_CH(8), .SAMPLE_W(12),
                 .FIFO_DEPTH(8), .TIMEOUT_CYCLES(16)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .adc_start(adc_start), .adc_chsel(adc_chsel), .adc_done(adc_done), .adc_data(adc_data),
      .irq(irq)
   );

   always #5 PCLK = ~PCLK;

   // Monitor: every APB access phase and every adc_start pulse is checked against the queues.
   always @(negedge PCLK) begin
      if (PSEL && PENABLE) begin
         total++;
         if (d_q.size() == 0) begin
            bad++;
            $display("FAIL apb_unexpected: access with no expectation, rdata=%h", PRDATA);
         end else begin
            m_nm = nm_q.pop_front();
            m_d  = d_q.pop_front();
            m_e  = e_q.pop_front();
            if (PRDATA !== m_d || PSLVERR !== m_e) begin
               bad++;
               $display("FAIL %s: got rdata=%h err=%b, want rdata=%h err=%b", m_nm, PRDATA, PSLVERR, m_d, m_e);
            end
         end
      end
      if (adc_start) begin
         total++;
         if (start_q.size() == 0) begin
            bad++;
            $display("FAIL extra_adc_start: chsel=%0d, want no start", adc_chsel);
         end else begin
            m_ch = start_q.pop_front();
            if (adc_chsel !== m_ch) begin
               bad++;
               $display("FAIL adc_chsel: got %0d want %0d", adc_chsel, m_ch);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic apb(input bit wr, input logic [11:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_d, input logic exp_e,
                      input bit with_done, input logic [11:0] dv, input string nm);
      nm_q.push_back(nm);
      d_q.push_back(exp_d);
      e_q.push_back(exp_e);
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = wd;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      if (with_done) begin
         adc_done = 1'b1;
         adc_data = dv;
      end
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; adc_done = 1'b0;
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] wd, input logic e, input string nm);
      apb(1'b1, a, wd, 32'h0, e, 1'b0, 12'h0, nm);
   endtask

   task automatic rd(input logic [11:0] a, input logic [31:0] exp, input logic e, input string nm);
      apb(1'b0, a, 32'h0, exp, e, 1'b0, 12'h0, nm);
   endtask

   task automatic wait_start(input string nm);
      bit seen = 1'b0;
      for (int i = 0; i < 64 && !seen; i++) begin
         @(negedge PCLK);
         if (adc_start) seen = 1'b1;
      end
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL %s: no adc_start within 64 cycles", nm);
      end
   endtask

   task automatic give_done(input int n, input logic [11:0] v);
      repeat (n) @(posedge PCLK);
      #1; adc_done = 1'b1; adc_data = v;
      @(posedge PCLK); #1; adc_done = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge PCLK);
      chk("rst_prdata", PRDATA, 32'h0);
      chk("rst_pslverr", {31'h0, PSLVERR}, 32'h0);
      chk("rst_adc_start", {31'h0, adc_start}, 32'h0);
      chk("rst_adc_chsel", {29'h0, adc_chsel}, 32'h0);
      chk("rst_irq", {31'h0, irq}, 32'h0);
      chk("pready", {31'h0, PREADY}, 32'h1);
      #1 PRESETn = 1'b1;
      rd(A_STATUS, 32'h0000_0002, 1'b0, "rst_status");
      rd(A_CTRL, 32'h0, 1'b0, "rst_ctrl");
      rd(A_CHMASK, 32'h0, 1'b0, "rst_chmask");

      // Single scan over channels 0 and 2.
      wr(A_CHMASK, 32'h05, 1'b0, "single_chmask");
      wr(A_CTRL, 32'h1, 1'b0, "single_ctrl");
      start_q.push_back(3'd0);
      start_q.push_back(3'd2);
      wr(A_TRIG, 32'h1, 1'b0, "single_trig");
      wait_start("single_s0");
      give_done(4, 12'hABC);
      wait_start("single_s1");
      give_done(4, 12'h123);
      repeat (4) @(posedge PCLK);
      rd(A_STATUS, 32'h0000_0200, 1'b0, "single_status");
      rd(A_DATA, 32'h8000_0ABC, 1'b0, "single_data0");
      rd(A_DATA, 32'h8002_0123, 1'b0, "single_data1");
      rd(A_DATA, 32'h0, 1'b0, "single_data_empty");
      rd(A_STATUS, 32'h0000_0002, 1'b0, "single_status_end");

      // Continuous scan on channel 7, stopped by clearing CTRL on the third conversion.
      wr(A_CHMASK, 32'h80, 1'b0, "cont_chmask");
      wr(A_CTRL, 32'h3, 1'b0, "cont_ctrl");
      for (int i = 0; i < 3; i++) start_q.push_back(3'd7);
      wr(A_TRIG, 32'h1, 1'b0, "cont_trig");
      wait_start("cont_s0");
      give_done(4, 12'h111);
      wait_start("cont_s1");
      give_done(4, 12'h222);
      wait_start("cont_s2");
      apb(1'b1, A_CTRL, 32'h0, 32'h0, 1'b0, 1'b1, 12'h333, "cont_stop");
      rd(A_STATUS, 32'h0000_0300, 1'b0, "cont_idle");
      repeat (20) @(posedge PCLK);
      rd(A_DATA, 32'h8007_0111, 1'b0, "cont_data0");
      rd(A_DATA, 32'h8007_0222, 1'b0, "cont_data1");
      rd(A_DATA, 32'h8007_0333, 1'b0, "cont_data2");
      rd(A_STATUS, 32'h0000_0002, 1'b0, "cont_status_end");

      // Overflow: nine conversions into an eight-entry FIFO.
      wr(A_CHMASK, 32'h01, 1'b0, "ovf_chmask");
      for (int i = 0; i < 9; i++) start_q.push_back(3'd0);
      wr(A_CTRL, 32'h3, 1'b0, "ovf_ctrl");
      wr(A_TRIG, 32'h1, 1'b0, "ovf_trig");
      for (int i = 0; i < 9; i++) begin
         wait_start("ovf_start");
         if (i < 8) give_done(2, 12'(12'h100 + i));
         else       apb(1'b1, A_CTRL, 32'h0, 32'h0, 1'b0, 1'b1, 12'h108, "ovf_stop");
      end
      rd(A_STATUS, 32'h0000_080C, 1'b0, "ovf_status");
      chk("ovf_irq_masked", {31'h0, irq}, 32'h0);
      wr(A_CTRL, 32'h4, 1'b0, "ovf_irq_en");
      chk("ovf_irq", {31'h0, irq}, 32'h1);
      wr(A_STATUS, 32'h08, 1'b0, "ovf_w1c");
      rd(A_STATUS, 32'h0000_0804, 1'b0, "ovf_cleared");
      rd(A_DATA, 32'h8000_0100, 1'b0, "ovf_oldest");
      rd(A_STATUS, 32'h0000_0700, 1'b0, "ovf_level7");

      // Refill, then pop and push in the same cycle while full.
      wr(A_CTRL, 32'h5, 1'b0, "full_ctrl");
      start_q.push_back(3'd0);
      wr(A_TRIG, 32'h1, 1'b0, "full_trig0");
      wait_start("full_s0");
      give_done(2, 12'h200);
      repeat (3) @(posedge PCLK);
      rd(A_STATUS, 32'h0000_0804, 1'b0, "full_refill");
      start_q.push_back(3'd0);
      wr(A_TRIG, 32'h1, 1'b0, "full_trig1");
      wait_start("full_s1");
      apb(1'b0, A_DATA, 32'h0, 32'h8000_0101, 1'b0, 1'b1, 12'h201, "full_pop_push");
      repeat (3) @(posedge PCLK);
      rd(A_STATUS, 32'h0000_0804, 1'b0, "full_level_kept");
      rd(A_DATA, 32'h8000_0102, 1'b0, "full_next");
      rd(A_STATUS, 32'h0000_0700, 1'b0, "full_level7");

      // Reset in the middle of a conversion.
      start_q.push_back(3'd0);
      wr(A_TRIG, 32'h1, 1'b0, "rst_trig");
      wait_start("rst_s0");
      @(posedge PCLK); #1 PRESETn = 1'b0;
      #1;
      chk("rst_mid_start", {31'h0, adc_start}, 32'h0);
      chk("rst_mid_irq", {31'h0, irq}, 32'h0);
      @(posedge PCLK); #1 PRESETn = 1'b1;
      rd(A_STATUS, 32'h0000_0002, 1'b0, "rst_mid_status");
      rd(A_CTRL, 32'h0, 1'b0, "rst_mid_ctrl");

      // Error responses and a TRIG while busy.
      wr(A_CHMASK, 32'hFFFF_FFFF, 1'b0, "err_chmask_all");
      rd(A_CHMASK, 32'h0000_00FF, 1'b0, "err_chmask_rd");
      wr(A_CHMASK, 32'h01, 1'b0, "err_chmask1");
      wr(A_CTRL, 32'h1, 1'b0, "err_ctrl");
      rd(12'h020, 32'h0, 1'b1, "err_rd_0x20");
      wr(12'h014, 32'hFFFF_FFFF, 1'b1, "err_wr_0x14");
      rd(A_CTRL, 32'h1, 1'b0, "err_ctrl_kept");
      rd(A_CHMASK, 32'h1, 1'b0, "err_chmask_kept");
      rd(A_TRIG, 32'h0, 1'b0, "err_trig_rd");
      rd(A_STATUS, 32'h0000_0002, 1'b0, "err_status_kept");
      start_q.push_back(3'd0);
      wr(A_TRIG, 32'h1, 1'b0, "busy_trig0");
      wait_start("busy_s0");
      wr(A_TRIG, 32'h1, 1'b0, "busy_trig1");
      give_done(1, 12'h0AA);
      repeat (10) @(posedge PCLK);
      rd(A_STATUS, 32'h0000_0100, 1'b0, "busy_status");
      rd(A_DATA, 32'h8000_00AA, 1'b0, "busy_data");
      rd(A_STATUS, 32'h0000_0002, 1'b0, "busy_status_end");

      // Conversion that never completes.
      wr(A_CTRL, 32'h5, 1'b0, "tmo_ctrl");
      start_q.push_back(3'd0);
      wr(A_TRIG, 32'h1, 1'b0, "tmo_trig");
      wait_start("tmo_s0");
`ifdef ADC_SEQ_TIMEOUT_EN
      repeat (14) @(posedge PCLK);
      rd(A_STATUS, 32'h0000_0003, 1'b0, "tmo_still_busy");
      rd(A_STATUS, 32'h0000_0012, 1'b0, "tmo_status");
      chk("tmo_irq", {31'h0, irq}, 32'h1);
      wr(A_STATUS, 32'h10, 1'b0, "tmo_w1c");
      rd(A_STATUS, 32'h0000_0002, 1'b0, "tmo_cleared");
      chk("tmo_irq_clear", {31'h0, irq}, 32'h0);
`else
      repeat (40) @(posedge PCLK);
      rd(A_STATUS, 32'h0000_0003, 1'b0, "hold_status");
      chk("hold_irq", {31'h0, irq}, 32'h0);
      give_done(1, 12'h0BB);
      repeat (3) @(posedge PCLK);
      rd(A_DATA, 32'h8000_00BB, 1'b0, "hold_data");
      rd(A_STATUS, 32'h0000_0002, 1'b0, "hold_status_end");
`endif

      repeat (5) @(posedge PCLK);
      chk("start_q_drained", start_q.size(), 32'h0);
      chk("apb_q_drained", d_q.size(), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
